// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator subsystem: FSM encodings, floor numbers
// and beam polarity.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    PASS   = 2'd2
  } state_t;

  localparam logic [1:0] FLOOR1 = 2'd1;
  localparam logic [1:0] FLOOR2 = 2'd2;
  localparam logic [1:0] FLOOR3 = 2'd3;

  localparam logic BEAM_ON  = 1'b0;
  localparam logic BEAM_OFF = 1'b1;

  localparam logic [2:0] BEAMS_ALL_OFF = {3{BEAM_OFF}};

  // Beam vector (bit 0 = floor 1) with only the given floor's beam active.
  function automatic logic [2:0] beam_for(input logic [1:0] floor);
    logic [2:0] b;
    b = BEAMS_ALL_OFF;
    case (floor)
      FLOOR1:  b[0] = BEAM_ON;
      FLOOR2:  b[1] = BEAM_ON;
      FLOOR3:  b[2] = BEAM_ON;
      default: b = BEAMS_ALL_OFF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tick_cnt.sv
// Loadable down-counter with a terminal-count flag; holds at zero instead of
// wrapping so callers can reload at their leisure.
module tick_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/floorsense_gen.sv
// Floor-sensor stimulus generator: moves a virtual car between three floors and
// drives the active-low beam lines with levels long enough for the edge filter.
module floorsense_gen
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYC = 16,
  parameter int PASS_CYC   = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       go,
  input  logic [1:0] target,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_floor,
  output logic       dir_up,
  output logic       red1_out,
  output logic       red2_out,
  output logic       red3_out
);

  localparam logic [15:0] TRAVEL_LD = 16'(TRAVEL_CYC - 1);
  localparam logic [15:0] PASS_LD   = 16'(PASS_CYC - 1);

  state_t      state, state_nxt;
  logic [1:0]  tgt, tgt_nxt;
  logic [2:0]  beam, beam_nxt;
  logic        busy_nxt, done_nxt, dir_nxt;
  logic [1:0]  cur_nxt, next_floor;
  logic        cnt_load, cnt_en, cnt_zero;
  logic [15:0] cnt_val, cnt_count;

  tick_cnt #(.W(16)) u_tick (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_val),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  assign cnt_en     = (state != IDLE);
  assign next_floor = dir_up ? (cur_floor + 2'd1) : (cur_floor - 2'd1);

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    beam_nxt  = beam;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    cur_nxt   = cur_floor;
    dir_nxt   = dir_up;
    cnt_load  = 1'b0;
    cnt_val   = TRAVEL_LD;
    case (state)
      IDLE: begin
        if (go && (target != 2'd0)) begin
          if (target == cur_floor) begin
            done_nxt = 1'b1;
          end else begin
            tgt_nxt   = target;
            dir_nxt   = (target > cur_floor);
            beam_nxt  = BEAMS_ALL_OFF;
            busy_nxt  = 1'b1;
            cnt_load  = 1'b1;
            cnt_val   = TRAVEL_LD;
            state_nxt = TRAVEL;
          end
        end
      end
      TRAVEL: begin
        if (cnt_zero) begin
          cur_nxt  = next_floor;
          beam_nxt = beam_for(next_floor);
          if (next_floor == tgt) begin
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            cnt_load  = 1'b1;
            cnt_val   = PASS_LD;
            state_nxt = PASS;
          end
        end
      end
      PASS: begin
        if (cnt_zero) begin
          beam_nxt  = BEAMS_ALL_OFF;
          cnt_load  = 1'b1;
          cnt_val   = TRAVEL_LD;
          state_nxt = TRAVEL;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset parks the car at floor 1 with its beam active.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      tgt       <= FLOOR1;
      beam      <= beam_for(FLOOR1);
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_floor <= FLOOR1;
      dir_up    <= 1'b1;
    end else begin
      state     <= state_nxt;
      tgt       <= tgt_nxt;
      beam      <= beam_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      cur_floor <= cur_nxt;
      dir_up    <= dir_nxt;
    end
  end

  assign red1_out = beam[0];
  assign red2_out = beam[1];
  assign red3_out = beam[2];

endmodule

// File: tb/tb_floorsense_gen.sv
// Self-checking bench for floorsense_gen: timeline model of car motion plus
// directed literal checks and randomized go/target traffic.
module tb_floorsense_gen;

  localparam int T = 16;
  localparam int P = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       go = 1'b0;
  logic [1:0] target = 2'd0;
  logic       busy, done, dir_up, red1_out, red2_out, red3_out;
  logic [1:0] cur_floor;

  floorsense_gen #(.TRAVEL_CYC(T), .PASS_CYC(P)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .go        (go),
    .target    (target),
    .busy      (busy),
    .done      (done),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .red1_out  (red1_out),
    .red2_out  (red2_out),
    .red3_out  (red3_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  int cc     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a move is a start floor, a goal and the cycles elapsed since acceptance.
  bit m_mov  = 1'b0;
  int m_s    = 1;
  int m_g    = 1;
  int m_e    = 0;
  int m_cur  = 1;
  bit m_dir  = 1'b1;
  bit m_done = 1'b0;

  function automatic int arrive_at(input int s, input int g);
    int d;
    d = (g > s) ? g - s : s - g;
    return 1 + d * T + (d - 1) * P;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mov  = 1'b0;
      m_cur  = 1;
      m_dir  = 1'b1;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mov) begin
        m_e++;
        if (m_e == arrive_at(m_s, m_g)) begin
          m_mov  = 1'b0;
          m_cur  = m_g;
          m_done = 1'b1;
        end
      end else if (go && target != 2'd0) begin
        if (int'(target) == m_cur) begin
          m_done = 1'b1;
        end else begin
          m_mov = 1'b1;
          m_s   = m_cur;
          m_g   = int'(target);
          m_e   = 1;
          m_dir = (int'(target) > m_cur);
        end
      end
    end
  end

  always @(negedge clk) begin
    int p, q, leg, step, ecur, eb, ebusy;
    if (chk_en) begin
      if (m_mov) begin
        p    = m_e - 1;
        q    = p % (T + P);
        leg  = p / (T + P);
        step = m_dir ? 1 : -1;
        if (q < T) begin
          ecur = m_s + step * leg;
          eb   = 7;
        end else begin
          ecur = m_s + step * (leg + 1);
          eb   = 7 & ~(1 << (ecur - 1));
        end
        ebusy = 1;
      end else begin
        ecur  = m_cur;
        eb    = 7 & ~(1 << (m_cur - 1));
        ebusy = 0;
      end
      check("busy", int'(busy), ebusy);
      check("done", int'(done), int'(m_done));
      check("cur_floor", int'(cur_floor), ecur);
      check("dir_up", int'(dir_up), int'(m_dir));
      check("beams", int'({red3_out, red2_out, red1_out}), eb);
    end
  end

  task automatic issue(input logic [1:0] t);
    @(negedge clk);
    go = 1'b1;
    target = t;
    @(negedge clk);
    go = 1'b0;
    cc = 1;
  endtask

  task automatic goto(input int k);
    while (cc < k) begin
      @(negedge clk);
      cc++;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #2 rstn = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_cur_floor", int'(cur_floor), 1);
    check("rst_beams", int'({red3_out, red2_out, red1_out}), 6);
    check("rst_busy", int'(busy), 0);
    #2 rstn = 1'b1;

    // 1 -> 2
    issue(2'd2);
    check("t1_c1_red1", int'(red1_out), 1);
    check("t1_c1_busy", int'(busy), 1);
    goto(16);
    check("t1_c16_red2", int'(red2_out), 1);
    goto(17);
    check("t1_c17_red2", int'(red2_out), 0);
    check("t1_c17_done", int'(done), 1);
    check("t1_c17_cur", int'(cur_floor), 2);

    // 1 -> 3
    reset_pulse();
    issue(2'd3);
    goto(17);
    check("t2_c17_red2", int'(red2_out), 0);
    check("t2_c17_done", int'(done), 0);
    goto(24);
    check("t2_c24_red2", int'(red2_out), 0);
    goto(25);
    check("t2_c25_beams", int'({red3_out, red2_out, red1_out}), 7);
    goto(40);
    check("t2_c40_beams", int'({red3_out, red2_out, red1_out}), 7);
    goto(41);
    check("t2_c41_red3", int'(red3_out), 0);
    check("t2_c41_done", int'(done), 1);
    check("t2_c41_dir", int'(dir_up), 1);

    // 3 -> 1
    issue(2'd1);
    goto(17);
    check("t3_c17_red2", int'(red2_out), 0);
    check("t3_c17_dir", int'(dir_up), 0);
    goto(41);
    check("t3_c41_red1", int'(red1_out), 0);
    check("t3_c41_done", int'(done), 1);

    // 1 -> 2 with an ignored go mid-move
    issue(2'd2);
    goto(4);
    go = 1'b1;
    target = 2'd3;
    goto(5);
    go = 1'b0;
    goto(17);
    check("t4_c17_cur", int'(cur_floor), 2);
    check("t4_c17_done", int'(done), 1);
    goto(18);
    check("t4_c18_done", int'(done), 0);

    // null and illegal moves at floor 2
    issue(2'd2);
    check("null_done", int'(done), 1);
    check("null_busy", int'(busy), 0);
    check("null_beams", int'({red3_out, red2_out, red1_out}), 5);
    issue(2'd0);
    check("illegal_done", int'(done), 0);
    check("illegal_beams", int'({red3_out, red2_out, red1_out}), 5);

    // reset mid 1 -> 3 move
    reset_pulse();
    issue(2'd3);
    goto(20);
    #2 rstn = 1'b0;
    #1;
    check("abort_beams", int'({red3_out, red2_out, red1_out}), 6);
    check("abort_busy", int'(busy), 0);
    check("abort_cur", int'(cur_floor), 1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (50) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      go = ($urandom_range(0, 5) == 0);
      target = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    go = 1'b0;
    repeat (80) @(negedge clk);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
